// File: rtl/mlp_sequencer.sv
// Two-layer MLP risk classifier: a single shared 16x16 MAC walks a synchronous
// weight ROM through a clamped-ReLU hidden layer and a linear output neuron.
module mlp_sequencer #(
  parameter int N_IN  = 6,
  parameter int N_HID = 7
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [16*N_IN-1:0] x_flat,
  output logic [5:0]         w_addr,
  input  logic [15:0]        w_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic [31:0]        y_out
);
  localparam int CNT_W = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 2);
  localparam int NEU_W = $clog2(N_HID + 1);
  localparam logic [CNT_W-1:0] HID_LAST  = CNT_W'(N_IN);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(N_HID);
  localparam logic [CNT_W-1:0] OUT_DRAIN = CNT_W'(N_HID + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [NEU_W-1:0] LAST_NEU  = NEU_W'(N_HID - 1);
  localparam logic [5:0]       OUT_BASE  = 6'(N_HID * (N_IN + 1));
  localparam logic signed [31:0] ONE_Q16 = 32'sh0001_0000;
  localparam logic signed [31:0] TH3     = 32'sh0000_999A;
  localparam logic signed [31:0] TH2     = 32'sh0000_8000;
  localparam logic signed [31:0] TH1     = 32'sh0000_6666;

  typedef enum logic [2:0] {
    S_IDLE, S_HID_MAC, S_HID_ACT, S_OUT_MAC, S_CLASSIFY, S_FINISH
  } state_t;

  state_t              r_state, w_next;
  logic [16*N_IN-1:0]  r_x;
  logic [16*N_HID-1:0] r_hid;
  logic signed [31:0]  r_acc;
  logic [5:0]          r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [NEU_W-1:0]    r_neuron;
  logic signed [31:0]  r_y;
  logic [1:0]          r_result;

  logic [CNT_W-1:0]    w_word;
  logic signed [15:0]  w_op;
  logic signed [31:0]  w_prod;
  logic signed [31:0]  w_bias;
  logic signed [31:0]  w_hsum;
  logic [15:0]         w_hval;
  logic [1:0]          w_class;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_next = S_HID_MAC;
      S_HID_MAC: begin
        busy = 1'b1;
        if (r_cnt == HID_LAST) w_next = S_HID_ACT;
      end
      S_HID_ACT: begin
        busy   = 1'b1;
        w_next = (r_neuron == LAST_NEU) ? S_OUT_MAC : S_HID_MAC;
      end
      S_OUT_MAC: begin
        busy = 1'b1;
        if (r_cnt == OUT_DRAIN) w_next = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        busy   = 1'b1;
        w_next = S_FINISH;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  // ROM data lags the address by one cycle, so count value c consumes word c-1.
  assign w_word = r_cnt - 1'b1;

  always_comb begin
    w_op = 16'sd0;
    if (r_state == S_OUT_MAC) w_op = r_hid[16*w_word +: 16];
    else                      w_op = r_x[16*w_word +: 16];
  end

  assign w_prod = $signed(w_data) * w_op;
  assign w_bias = {{8{w_data[15]}}, w_data, 8'h00};
  assign w_hsum = r_acc + w_bias;

  always_comb begin
    w_hval = w_hsum[23:8];
    if (w_hsum[31])            w_hval = 16'h0000;
    else if (w_hsum > ONE_Q16) w_hval = 16'h0100;
  end

  always_comb begin
    w_class = 2'd0;
    if (r_acc > TH3)      w_class = 2'd3;
    else if (r_acc > TH2) w_class = 2'd2;
    else if (r_acc > TH1) w_class = 2'd1;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_x      <= '0;
      r_hid    <= '0;
      r_acc    <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_neuron <= '0;
      r_y      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x      <= x_flat;
          r_addr   <= '0;
          r_cnt    <= '0;
          r_neuron <= '0;
        end
        S_HID_MAC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt != HID_LAST) r_addr <= r_addr + 1'b1;
          if (r_cnt == CNT_ONE)  r_acc  <= w_prod;
          else if (r_cnt != '0)  r_acc  <= r_acc + w_prod;
        end
        S_HID_ACT: begin
          r_hid[16*r_neuron +: 16] <= w_hval;
          r_cnt    <= '0;
          r_neuron <= r_neuron + 1'b1;
          r_addr   <= (r_neuron == LAST_NEU) ? OUT_BASE : r_addr + 1'b1;
        end
        S_OUT_MAC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt < OUT_LAST)        r_addr <= r_addr + 1'b1;
          if (r_cnt == CNT_ONE)        r_acc  <= w_prod;
          else if (r_cnt == OUT_DRAIN) r_acc  <= r_acc + w_bias;
          else if (r_cnt != '0)        r_acc  <= r_acc + w_prod;
        end
        S_CLASSIFY: begin
          r_y      <= r_acc;
          r_result <= w_class;
        end
        S_FINISH: r_addr <= '0;
        default: ;
      endcase
    end
  end

  assign w_addr = r_addr;
  assign result = r_result;
  assign y_out  = r_y;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: directed scenarios and randomized ROM/input sets,
// checked against an arithmetic reference of the two-layer network.
module tb_mlp_sequencer;
  localparam int N_IN     = 6;
  localparam int N_HID    = 7;
  localparam int HB       = N_IN + 1;
  localparam int OUT_BASE = N_HID * HB;
  localparam int OUT_BIAS = N_HID * (N_IN + 2);

  logic               clk;
  logic               clear;
  logic               start;
  logic [16*N_IN-1:0] x_flat;
  logic [5:0]         w_addr;
  logic [15:0]        w_data;
  logic               busy;
  logic               done;
  logic [1:0]         result;
  logic [31:0]        y_out;

  logic signed [15:0] rom [64];
  logic signed [15:0] x_vals [N_IN];
  int total;
  int bad;
  int done_cnt = 0;

  mlp_sequencer #(.N_IN(N_IN), .N_HID(N_HID)) dut (
    .clk(clk), .clear(clear), .start(start), .x_flat(x_flat),
    .w_addr(w_addr), .w_data(w_data), .busy(busy), .done(done),
    .result(result), .y_out(y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) w_data <= rom[w_addr];
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic apply_x();
    for (int k = 0; k < N_IN; k++) x_flat[16*k +: 16] = x_vals[k];
  endtask

  task automatic rom_pattern(input logic [15:0] hw, input logic [15:0] hb,
                             input logic [15:0] ow, input logic [15:0] ob);
    for (int i = 0; i < 64; i++) rom[i] = 16'sd0;
    for (int h = 0; h < N_HID; h++) begin
      for (int k = 0; k < N_IN; k++) rom[h*HB+k] = hw;
      rom[h*HB+N_IN]  = hb;
      rom[OUT_BASE+h] = ow;
    end
    rom[OUT_BIAS] = ob;
  endtask

  task automatic rom_random(input bit full, input int span);
    int v;
    for (int i = 0; i < 64; i++) begin
      v = int'($urandom_range(0, 32'(2*span))) - span;
      rom[i] = full ? 16'($urandom) : 16'(v);
    end
  endtask

  task automatic x_random(input bit full);
    int v;
    for (int k = 0; k < N_IN; k++) begin
      v = int'($urandom_range(0, 1024)) - 512;
      x_vals[k] = full ? 16'($urandom) : 16'(v);
    end
    apply_x();
  endtask

  // Network evaluated directly from the ROM map with 32-bit wrapping integers.
  function automatic void model(output logic [31:0] y, output logic [1:0] cls);
    int s;
    int acc;
    int hv [N_HID];
    for (int h = 0; h < N_HID; h++) begin
      s = 0;
      for (int k = 0; k < N_IN; k++) s += int'(rom[h*HB+k]) * int'(x_vals[k]);
      s += int'(rom[h*HB+N_IN]) * 256;
      if (s < 0) s = 0;
      else if (s > 65536) s = 65536;
      hv[h] = s / 256;
    end
    acc = int'(rom[OUT_BIAS]) * 256;
    for (int h = 0; h < N_HID; h++) acc += int'(rom[OUT_BASE+h]) * hv[h];
    y = acc;
    if (acc > 39322)      cls = 2'd3;
    else if (acc > 32768) cls = 2'd2;
    else if (acc > 26214) cls = 2'd1;
    else                  cls = 2'd0;
  endfunction

  task automatic run_check(input string tag, input logic [31:0] exp_y, input logic [1:0] exp_r);
    int lat;
    int d0;
    lat = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    d0 = done_cnt;
    check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check($sformatf("%s_lat", tag), 32'(lat), 32'd66);
    check($sformatf("%s_y", tag), y_out, exp_y);
    check($sformatf("%s_res", tag), 32'(result), 32'(exp_r));
    check($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s_idle_addr", tag), 32'(w_addr), 32'd0);
    check($sformatf("%s_ndone", tag), 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [31:0] ey;
    logic [1:0]  er;
    int lat;
    int d0;
    total  = 0;
    bad    = 0;
    clear  = 1'b1;
    start  = 1'b0;
    x_flat = '0;
    for (int i = 0; i < 64; i++) rom[i] = 16'sd0;
    for (int k = 0; k < N_IN; k++) x_vals[k] = 16'sd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_y", y_out, 32'd0);
    check("rst_addr", 32'(w_addr), 32'd0);
    @(negedge clk) clear = 1'b0;

    x_random(1'b1);
    run_check("zero_rom", 32'h0000_0000, 2'd0);
    rom_pattern(16'h0000, 16'h0100, 16'h0080, 16'h0000);
    run_check("unit_hidden", 32'h0003_8000, 2'd3);
    rom_pattern(16'h0000, 16'h7F00, 16'h0100, 16'h0000);
    run_check("clamp_hi", 32'h0007_0000, 2'd3);
    rom_pattern(16'h0000, 16'hFF00, 16'h0100, 16'h0000);
    run_check("clamp_lo", 32'h0000_0000, 2'd0);
    rom_pattern(16'h0000, 16'h0000, 16'h0100, 16'h0080);
    run_check("thr_8000", 32'h0000_8000, 2'd1);
    rom_pattern(16'h0000, 16'h0000, 16'h0100, 16'h0067);
    run_check("thr_6700", 32'h0000_6700, 2'd1);
    rom_pattern(16'h0000, 16'h0000, 16'h0100, 16'h0081);
    run_check("thr_8100", 32'h0000_8100, 2'd2);
    rom_pattern(16'h0000, 16'h0000, 16'h0100, 16'h009A);
    run_check("thr_9a00", 32'h0000_9A00, 2'd3);

    // abort mid-run with clear, then restart
    rom_pattern(16'h0000, 16'h0100, 16'h0080, 16'h0000);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #2 clear = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(w_addr), 32'd0);
    check("abort_y", y_out, 32'd0);
    @(negedge clk) clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_nodone", 32'(done_cnt - d0), 32'd0);
    run_check("restart", 32'h0003_8000, 2'd3);

    // clear and start together
    @(negedge clk); start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    check("clr_start_busy", 32'(busy), 32'd0);
    @(negedge clk); clear = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("clr_start_idle", 32'(busy), 32'd0);

    // start held across done: only accepted once back in IDLE
    rom_pattern(16'h0000, 16'h0100, 16'h0080, 16'h0000);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 65) start = 1'b1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("b2b_lat1", 32'(lat), 32'd66);
    @(posedge clk); #1;
    check("b2b_not_yet", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept", 32'(busy), 32'd1);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("b2b_lat2", 32'(lat), 32'd66);
    check("b2b_y", y_out, 32'h0003_8000);
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      rom_random(t == 7, 320);
      x_random(t == 7);
      model(ey, er);
      run_check($sformatf("rand%0d", t), ey, er);
    end

    // second start and x change during a run are ignored
    rom_random(1'b0, 320);
    x_random(1'b0);
    model(ey, er);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    d0 = done_cnt;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 5)  x_flat = {$urandom, $urandom, $urandom};
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (done && lat == 0) lat = c;
    end
    check("ignore_lat", 32'(lat), 32'd66);
    check("ignore_y", y_out, ey);
    check("ignore_res", 32'(result), 32'(er));
    check("ignore_ndone", 32'(done_cnt - d0), 32'd1);
    check("ignore_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_sequencer.md
MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 Parameter N_IN, default 6, number of classifier inputs.
REQ-002 Parameter N_HID, default 7, number of hidden-layer neurons.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clear  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request one inference; sampled only in IDLE.
REQ-006 x_flat  input  16*N_IN  signed Q8.8 inputs; input k occupies bits [16k+15:16k]; captured on the start-accept edge.
REQ-007 w_addr  output  6  registered weight-ROM address.
REQ-008 w_data  input  16  signed Q8.8 ROM word; valid exactly one cycle after w_addr changes (synchronous ROM).
REQ-009 busy  output  1  high from the start-accept edge until done is asserted.
REQ-010 done  output  1  one-cycle pulse when result and y_out are updated.
REQ-011 result  output  2  risk class 0..3; holds its value until the next done.
REQ-012 y_out  output  32  signed Q16.16 raw output-layer sum; holds its value until the next done.

Function
REQ-013 The block SHALL contain exactly one 16x16 signed multiplier feeding a 32-bit signed accumulator, time-shared across all neurons.
REQ-014 ROM map: hidden neuron h, input k at address h*(N_IN+1)+k, hidden bias at h*(N_IN+1)+N_IN; output weight h at N_HID*(N_IN+1)+h; output bias at N_HID*(N_IN+2).
REQ-015 States: IDLE, HID_MAC, HID_ACT, OUT_MAC, CLASSIFY, FINISH.
- IDLE->HID_MAC on start.
- HID_MAC->HID_ACT after the neuron's bias word.
- HID_ACT->HID_MAC for the next neuron, or ->OUT_MAC after neuron N_HID-1.
- OUT_MAC->CLASSIFY after the output bias word.
- CLASSIFY->FINISH->IDLE.
REQ-016 Addressing: one address per cycle, issued in ascending order; the accumulator clears at the first word of each neuron.
REQ-017 Accumulation: accumulator += w_data*operand, where operand is x[k] (hidden layer) or the Q8.8 hidden value h (output layer).
REQ-018 Bias words SHALL be added as sign-extended w_data<<8, which aligns them to Q16.16.
REQ-019 The accumulator SHALL wrap on overflow; no saturation is applied during accumulation.
REQ-020 HID_ACT SHALL clamp the hidden sum to [0x0000_0000, 0x0001_0000] (ReLU with upper bound 1.0), then store acc[23:8] as the Q8.8 hidden value.
REQ-021 Hidden register file size: N_HID entries of 16 bits.
REQ-022 CLASSIFY, comparisons signed and strict:
- y > 0x0000_999A -> result 3
- else y > 0x0000_8000 -> result 2
- else y > 0x0000_6666 -> result 1
- else result 0
REQ-023 Update timing: y_out and result SHALL update on the edge that asserts done.
REQ-024 Latency with defaults: done SHALL be high in the 66th cycle after the start-accept edge.
- Hidden layer: 7 neurons x (7 words + 1 activation cycle) = 56 cycles.
- Output layer: 8 words + 1 drain cycle = 9 cycles.
- CLASSIFY: 1 cycle.
REQ-025 start while busy SHALL be ignored: not queued, with no effect on the run in progress.
REQ-026 Changes on x_flat after the start-accept edge SHALL NOT affect the run in progress.
REQ-027 w_addr SHALL be 0 whenever the state is IDLE.
REQ-028 done and start in the same cycle: FINISH returns to IDLE, and the start is accepted only on a later cycle in IDLE.

Reset
REQ-029 While clear is high, the block SHALL immediately go to IDLE with busy=0, done=0, result=0, y_out=0, w_addr=0, accumulator and hidden registers zeroed.
REQ-030 clear asserted mid-run SHALL abort the run with no done pulse; a start after clear is released runs a full, correct inference.
REQ-031 clear and start asserted together: clear SHALL win.

Verification
REQ-032 All ROM words 0, any x -> done exactly 66 cycles after start, y_out=0x0000_0000, result=0.
REQ-033 Hidden biases 0x0100, other hidden words 0, output weights 0x0080, output bias 0 -> each h=0x0100, y_out=0x0003_8000, result=3.
REQ-034 Clamp check, output weights 0x0100:
- hidden biases 0x7F00 -> each h=0x0100, y_out=0x0007_0000, result=3
- hidden biases 0xFF00 -> each h=0, y_out=0, result=0
REQ-035 Threshold boundary, all hidden outputs 0:
- output bias 0x0080 -> y_out=0x0000_8000, result=1 (not 2)
- output bias 0x0067 -> y_out=0x0000_6700, result=1
REQ-036 clear pulsed 20 cycles after start -> busy falls immediately, w_addr=0, no done; a new start 3 cycles later gives the correct REQ-033 result at +66 cycles.
REQ-037 Second start at +10 cycles during a run, with x_flat changed at +5 -> exactly one done at +66, result computed from the originally captured x.
